// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared segment encodings and display-value types for the multiplexed 4-digit display.
// Segment vectors are ordered {a,b,c,d,e,f,g} and are active-low.
package seven_seg_scan_ctrl_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    localparam logic [6:0] GLYPH_0 = 7'b0000001;
    localparam logic [6:0] GLYPH_1 = 7'b1001111;
    localparam logic [6:0] GLYPH_2 = 7'b0010010;
    localparam logic [6:0] GLYPH_3 = 7'b0000110;
    localparam logic [6:0] GLYPH_4 = 7'b1001100;
    localparam logic [6:0] GLYPH_5 = 7'b0100100;
    localparam logic [6:0] GLYPH_6 = 7'b0100000;
    localparam logic [6:0] GLYPH_7 = 7'b0001111;
    localparam logic [6:0] GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0000100;
    localparam logic [6:0] GLYPH_A = 7'b0001000;
    localparam logic [6:0] GLYPH_B = 7'b1100000;
    localparam logic [6:0] GLYPH_C = 7'b0110001;
    localparam logic [6:0] GLYPH_D = 7'b1000010;
    localparam logic [6:0] GLYPH_E = 7'b0110000;
    localparam logic [6:0] GLYPH_F = 7'b0111000;

    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  dp;
    } dispValue_t;

    // Active-low one-cold anode pattern for a digit slot.
    function automatic logic [3:0] anodeFor(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Purely combinational hex-to-seven-segment decoder, active-low {a..g} output.
module seven_seg_decoder
    import seven_seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] hexDigit,
    output logic [6:0] segments
);

    always_comb begin
        segments = SEG_BLANK;
        case (hexDigit)
            4'h0: segments = GLYPH_0;
            4'h1: segments = GLYPH_1;
            4'h2: segments = GLYPH_2;
            4'h3: segments = GLYPH_3;
            4'h4: segments = GLYPH_4;
            4'h5: segments = GLYPH_5;
            4'h6: segments = GLYPH_6;
            4'h7: segments = GLYPH_7;
            4'h8: segments = GLYPH_8;
            4'h9: segments = GLYPH_9;
            4'hA: segments = GLYPH_A;
            4'hB: segments = GLYPH_B;
            4'hC: segments = GLYPH_C;
            4'hD: segments = GLYPH_D;
            4'hE: segments = GLYPH_E;
            4'hF: segments = GLYPH_F;
            default: segments = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed 4-digit seven-segment scanner with shadowed, frame-synchronous value
// updates, dead-time blanking between slots and optional leading-zero suppression.
module seven_seg_scan_ctrl
    import seven_seg_scan_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] din,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic        load_ack,
    output logic        frame_done,
    output logic [3:0]  an,
    output logic        segA,
    output logic        segB,
    output logic        segC,
    output logic        segD,
    output logic        segE,
    output logic        segF,
    output logic        segG,
    output logic        segDP
);

    localparam int               CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] prescale;
    logic [1:0]       digitIdx;
    logic             tick;
    logic             frameBoundary;
    dispValue_t       active;
    dispValue_t       shadow;
    dispValue_t       incoming;
    logic             pending;
    logic [3:0]       activeDigit;
    logic             activeDp;
    logic             blankDigit;
    logic [6:0]       decodedSeg;
    logic [6:0]       segReg;
    logic [3:0]       anReg;
    logic             dpReg;

    assign tick          = en && (prescale == CNT_LAST);
    assign frameBoundary = tick && (digitIdx == 2'd3);
    assign incoming      = '{digits: din, dp: dp_in};

    // Slot timing: disabling the scan parks it at digit 0 with a fresh prescale count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale <= '0;
            digitIdx <= '0;
        end else if (!en) begin
            prescale <= '0;
            digitIdx <= '0;
        end else if (tick) begin
            prescale <= '0;
            digitIdx <= digitIdx + 2'd1;
        end else begin
            prescale <= prescale + 1'b1;
        end
    end

    // Shadow/active handoff only at a frame boundary so a frame never mixes two values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active     <= '0;
            shadow     <= '0;
            pending    <= 1'b0;
            load_ack   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            load_ack   <= 1'b0;
            frame_done <= frameBoundary;
            if (frameBoundary && load) begin
                active   <= incoming;
                shadow   <= incoming;
                pending  <= 1'b0;
                load_ack <= 1'b1;
            end else if (frameBoundary && pending) begin
                active   <= shadow;
                pending  <= 1'b0;
                load_ack <= 1'b1;
            end else if (load) begin
                shadow  <= incoming;
                pending <= 1'b1;
            end
        end
    end

    assign activeDigit = active.digits[{digitIdx, 2'b00} +: 4];
    assign activeDp    = active.dp[digitIdx];

    // A digit is a leading zero only when it and every more significant digit are zero.
    always_comb begin
        blankDigit = 1'b0;
        case (digitIdx)
            2'd3:    blankDigit = (active.digits[15:12] == 4'h0);
            2'd2:    blankDigit = (active.digits[15:8] == 8'h0);
            2'd1:    blankDigit = (active.digits[15:4] == 12'h0);
            default: blankDigit = 1'b0;
        endcase
        blankDigit = blankDigit & blank_lz;
    end

    seven_seg_decoder uDecoder (
        .hexDigit (activeDigit),
        .segments (decodedSeg)
    );

    // The tick cycle loads all-off, giving one dead cycle before the next digit lights.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anReg  <= AN_OFF;
            segReg <= SEG_BLANK;
            dpReg  <= 1'b1;
        end else if (!en || tick) begin
            anReg  <= AN_OFF;
            segReg <= SEG_BLANK;
            dpReg  <= 1'b1;
        end else begin
            anReg  <= anodeFor(digitIdx);
            segReg <= blankDigit ? SEG_BLANK : decodedSeg;
            dpReg  <= ~activeDp;
        end
    end

    assign an = anReg;
    assign {segA, segB, segC, segD, segE, segF, segG} = segReg;
    assign segDP = dpReg;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Randomised and directed bench for seven_seg_scan_ctrl, checked every cycle against a
// cycle-count based behavioural model of the scan, blanking and load handoff.
module tb_seven_seg_scan_ctrl;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] din = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic        blank_lz = 1'b0;
    logic        load_ack;
    logic        frame_done;
    logic [3:0]  an;
    logic        segA, segB, segC, segD, segE, segF, segG, segDP;
    logic [6:0]  segs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seven_seg_scan_ctrl #(.TICK_DIV(TD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .din        (din),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .load_ack   (load_ack),
        .frame_done (frame_done),
        .an         (an),
        .segA       (segA),
        .segB       (segB),
        .segC       (segC),
        .segD       (segD),
        .segE       (segE),
        .segF       (segF),
        .segG       (segG),
        .segDP      (segDP)
    );

    assign segs = {segA, segB, segC, segD, segE, segF, segG};

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
        end
    endtask

    function automatic logic [6:0] tbGlyph(input int v);
        case (v)
            0:  return 7'b0000001;
            1:  return 7'b1001111;
            2:  return 7'b0010010;
            3:  return 7'b0000110;
            4:  return 7'b1001100;
            5:  return 7'b0100100;
            6:  return 7'b0100000;
            7:  return 7'b0001111;
            8:  return 7'b0000000;
            9:  return 7'b0000100;
            10: return 7'b0001000;
            11: return 7'b1100000;
            12: return 7'b0110001;
            13: return 7'b1000010;
            14: return 7'b0110000;
            15: return 7'b0111000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Leading zero: this digit and everything above it is zero, digit 0 excluded.
    function automatic logic [6:0] modelSeg(input int value, input int slot, input bit blz);
        if (blz && slot > 0 && (value >> (4 * slot)) == 0)
            return 7'b1111111;
        return tbGlyph((value >> (4 * slot)) & 15);
    endfunction

    int          eCount;
    int          phase;
    int          slot;
    bit          boundary;
    logic [15:0] mActive, mShadow;
    logic [3:0]  mDpA, mDpS;
    bit          mPend;
    logic [3:0]  expAn;
    logic [6:0]  expSeg;
    logic        expDp, expAck, expFd;

    // Model: position in the scan is just the number of consecutive enabled edges.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eCount = 0; mActive = 0; mShadow = 0; mDpA = 0; mDpS = 0; mPend = 0;
            expAn = 4'hF; expSeg = 7'h7F; expDp = 1'b1; expAck = 1'b0; expFd = 1'b0;
        end else begin
            expAn = 4'hF; expSeg = 7'h7F; expDp = 1'b1; expAck = 1'b0; expFd = 1'b0;
            boundary = 0;
            if (en) begin
                phase = eCount % TD;
                slot  = (eCount / TD) % 4;
                if (phase != TD - 1) begin
                    expAn  = 4'hF ^ (4'b0001 << slot);
                    expSeg = modelSeg(int'(mActive), slot, blank_lz);
                    expDp  = ~mDpA[slot];
                end else if (slot == 3) begin
                    boundary = 1;
                    expFd = 1'b1;
                    if (load) begin
                        mActive = din; mDpA = dp_in; mShadow = din; mDpS = dp_in;
                        mPend = 0; expAck = 1'b1;
                    end else if (mPend) begin
                        mActive = mShadow; mDpA = mDpS; mPend = 0; expAck = 1'b1;
                    end
                end
                eCount++;
            end else begin
                eCount = 0;
            end
            if (load && !boundary) begin
                mShadow = din; mDpS = dp_in; mPend = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            checkOutput("rst_an", 32'(an), 32'hF);
            checkOutput("rst_seg", 32'(segs), 32'h7F);
            checkOutput("rst_dp", 32'(segDP), 32'h1);
            checkOutput("rst_ack", 32'(load_ack), 32'h0);
            checkOutput("rst_fd", 32'(frame_done), 32'h0);
        end else begin
            checkOutput("an", 32'(an), 32'(expAn));
            checkOutput("seg", 32'(segs), 32'(expSeg));
            checkOutput("dp", 32'(segDP), 32'(expDp));
            checkOutput("load_ack", 32'(load_ack), 32'(expAck));
            checkOutput("frame_done", 32'(frame_done), 32'(expFd));
        end
    end

    int         ackCount = 0;
    int         fdCount = 0;
    logic [6:0] seenSeg [4];
    logic       seenDp  [4];

    always @(negedge clk) begin
        if (rst_n) begin
            if (load_ack) ackCount++;
            if (frame_done) fdCount++;
            for (int i = 0; i < 4; i++) begin
                if (an == 4'(~(4'b0001 << i))) begin
                    seenSeg[i] = segs;
                    seenDp[i]  = segDP;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input bit e, input bit l, input logic [15:0] d, input logic [3:0] p, input bit b);
        en = e; load = l; din = d; dp_in = p; blank_lz = b;
        step(1);
        load = 1'b0;
    endtask

    task automatic waitFrameDone();
        bit found;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (frame_done) begin
                found = 1;
                break;
            end
        end
        checkOutput("frame_done_seen", 32'(found), 32'h1);
    endtask

    int ackCycle;
    int ackBase;
    int fdBase;

    initial begin
        #1 rst_n = 1'b0;
        step(2);
        checkOutput("reset_an", 32'(an), 32'hF);
        checkOutput("reset_seg", 32'(segs), 32'h7F);
        checkOutput("reset_ack", 32'(load_ack), 32'h0);
        rst_n = 1'b1;
        step(1);

        // Load 1234 with the first enabled edge; ack follows the first frame boundary.
        ackCycle = -1;
        for (int k = 0; k < 36; k++) begin
            if (k == 0) applyStimulus(1'b1, 1'b1, 16'h1234, 4'h0, 1'b0);
            else step(1);
            if (load_ack && ackCycle < 0) ackCycle = k + 1;
        end
        checkOutput("first_ack_cycle", 32'(ackCycle), 32'd16);
        checkOutput("digit1_is_3", 32'(seenSeg[1]), 32'(7'b0000110));
        checkOutput("digit3_is_1", 32'(seenSeg[3]), 32'(7'b1001111));

        // Leading-zero blanking with decimal points on digits 0 and 2.
        applyStimulus(1'b1, 1'b1, 16'h0070, 4'b0101, 1'b1);
        step(40);
        checkOutput("lz_digit3", 32'(seenSeg[3]), 32'h7F);
        checkOutput("lz_digit2", 32'(seenSeg[2]), 32'h7F);
        checkOutput("lz_digit1", 32'(seenSeg[1]), 32'(7'b0001111));
        checkOutput("lz_digit0", 32'(seenSeg[0]), 32'(7'b0000001));
        checkOutput("dp_digit0", 32'(seenDp[0]), 32'h0);
        checkOutput("dp_digit1", 32'(seenDp[1]), 32'h1);
        checkOutput("dp_digit2_blanked", 32'(seenDp[2]), 32'h0);
        checkOutput("dp_digit3", 32'(seenDp[3]), 32'h1);
        blank_lz = 1'b0;
        step(20);
        checkOutput("nolz_digit3", 32'(seenSeg[3]), 32'(7'b0000001));

        // Three loads in one frame collapse into a single ack.
        waitFrameDone();
        ackBase = ackCount;
        applyStimulus(1'b1, 1'b1, 16'hAAAA, 4'h0, 1'b0);
        applyStimulus(1'b1, 1'b1, 16'hBBBB, 4'h0, 1'b0);
        applyStimulus(1'b1, 1'b1, 16'hC0DE, 4'h0, 1'b0);
        step(30);
        checkOutput("multi_load_acks", 32'(ackCount - ackBase), 32'd1);
        checkOutput("c0de_digit3", 32'(seenSeg[3]), 32'(7'b0110001));
        checkOutput("c0de_digit2", 32'(seenSeg[2]), 32'(7'b0000001));
        checkOutput("c0de_digit1", 32'(seenSeg[1]), 32'(7'b1000010));
        checkOutput("c0de_digit0", 32'(seenSeg[0]), 32'(7'b0110000));

        // Load landing exactly on the boundary edge.
        waitFrameDone();
        step(15);
        applyStimulus(1'b1, 1'b1, 16'h4321, 4'h0, 1'b0);
        checkOutput("boundary_ack", 32'(load_ack), 32'h1);

        // Disable mid-frame, load while disabled, then re-enable.
        step(5);
        fdBase = fdCount;
        ackBase = ackCount;
        applyStimulus(1'b0, 1'b0, 16'h4321, 4'h0, 1'b0);
        checkOutput("dis_an", 32'(an), 32'hF);
        checkOutput("dis_seg", 32'(segs), 32'h7F);
        checkOutput("dis_dp", 32'(segDP), 32'h1);
        applyStimulus(1'b0, 1'b1, 16'h5678, 4'h0, 1'b0);
        step(10);
        checkOutput("dis_no_fd", 32'(fdCount - fdBase), 32'd0);
        checkOutput("dis_no_ack", 32'(ackCount - ackBase), 32'd0);
        ackCycle = -1;
        for (int k = 0; k < 36; k++) begin
            if (k == 0) applyStimulus(1'b1, 1'b0, 16'h5678, 4'h0, 1'b0);
            else step(1);
            if (load_ack && ackCycle < 0) ackCycle = k + 1;
        end
        checkOutput("reenable_ack_cycle", 32'(ackCycle), 32'd16);

        // Reset while a load is pending discards it.
        waitFrameDone();
        applyStimulus(1'b1, 1'b1, 16'h9999, 4'hF, 1'b0);
        step(3);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_an", 32'(an), 32'hF);
        checkOutput("async_rst_seg", 32'(segs), 32'h7F);
        checkOutput("async_rst_dp", 32'(segDP), 32'h1);
        en = 1'b0;
        step(2);
        rst_n = 1'b1;
        ackBase = ackCount;
        applyStimulus(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
        step(40);
        checkOutput("rst_no_ack", 32'(ackCount - ackBase), 32'd0);
        for (int i = 0; i < 4; i++)
            checkOutput("rst_zero_digit", 32'(seenSeg[i]), 32'(7'b0000001));

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 19) != 0, $urandom_range(0, 9) == 0,
                          16'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
        end
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
